// File: rtl/ram8_bank.sv
// ram8_bank
//
// Eight-word by 16-bit register bank. This is the storage stage that feeds
// the 8-way 16-bit read multiplexer in the HACK memory hierarchy.
//
// A one-hot demux of `load` by `address` enables exactly one word register
// per cycle. All eight words are exported on `words` for the downstream
// read mux. `out` is the locally muxed word[address].
//
// The bank also provides:
//   - a synchronous bulk clear, and
//   - a sticky per-word written-status vector, used by the RAM64/RAM512
//     controllers above this bank.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst_n        synchronous active-low reset
//   in           write data, stored bit-exact
//   address      word select for both write and read
//   load         write strobe; word[address] <= in at the next edge
//   clear        synchronous clear of all words and status; beats load
//   out          word[address], combinational, no read latency
//   words        all words concatenated, word 0 in bits [WIDTH-1:0]
//   written      bit k set once word k is loaded since last reset/clear
//   any_written  OR-reduction of written
//
// Edge priority: reset, then clear, then load, then hold.
// There is no write-through: during a write cycle, out still shows the
// old word. The new value appears after the edge.

module ram8_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in,
    input  logic [2:0]             address,
    input  logic                   load,
    input  logic                   clear,
    output logic [WIDTH-1:0]       out,
    output logic [WIDTH*DEPTH-1:0] words,
    output logic [DEPTH-1:0]       written,
    output logic                   any_written
);

    // Word storage and sticky status.
    logic [WIDTH-1:0] word_q [DEPTH];
    logic [DEPTH-1:0] written_q;

    // One-hot register enables. At most one bit is set per cycle.
    logic [DEPTH-1:0] load_en;

    // 3-to-8 demux of the load strobe.
    always_comb begin
        load_en = '0;
        if (load) begin
            load_en[address] = 1'b1;
        end
    end

    // Storage update.
    // Reset and clear both zero everything; a load in the same cycle is
    // dropped. Writing 0 still marks the word as written, because status
    // tracks the strobe rather than the data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                word_q[k] <= '0;
            end
            written_q <= '0;
        end else if (clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                word_q[k] <= '0;
            end
            written_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (load_en[k]) begin
                    word_q[k]    <= in;
                    written_q[k] <= 1'b1;
                end
            end
        end
    end

    // Flatten the words for the downstream read mux.
    for (genvar g = 0; g < DEPTH; g++) begin : g_words
        assign words[g*WIDTH +: WIDTH] = word_q[g];
    end

    // 8-way read mux. Purely combinational, so out follows address
    // within the cycle.
    always_comb begin
        out = word_q[address];
    end

    assign written     = written_q;
    assign any_written = |written_q;

endmodule

// File: tb/tb_ram8_bank.sv
// Self-checking bench for ram8_bank.
//
// Structure:
//   - Driver tasks apply writes and update a reference model
//     (model/model_wr).
//   - Read expectations are pushed onto exp_q when the address is driven.
//   - The expectation is popped and compared when out is sampled on the
//     falling edge.

module tb_ram8_bank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  in_d;
  logic [2:0]   address;
  logic         load;
  logic         clear;
  logic [15:0]  out;
  logic [127:0] words;
  logic [7:0]   written;
  logic         any_written;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] model[8];
  logic [7:0]  model_wr;

  always #5 clk = ~clk;

  ram8_bank dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in_d),
    .address(address),
    .load(load),
    .clear(clear),
    .out(out),
    .words(words),
    .written(written),
    .any_written(any_written)
  );

  // ---------------- driver tasks ----------------

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    model_wr = 8'h00;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    address = a;
    in_d    = d;
    load    = 1'b1;
    @(posedge clk);
    #1;
    load     = 1'b0;
    model[a] = d;
    model_wr[a] = 1'b1;
  endtask

  // ---------------- scenario tasks ----------------

  task automatic test_reset();
    logic [15:0] exp;
    rst_n   = 1'b0;
    load    = 1'b1;
    clear   = 1'b0;
    in_d    = 16'hFFFF;
    address = 3'd4;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    load  = 1'b0;
    model_reset();
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      exp_q.push_back(model[a]);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (out !== exp) begin
        errors++;
        $display("FAIL reset_out addr=%0d got=%h exp=%h", a, out, exp);
      end
    end
    checks++;
    if (written !== 8'h00) begin
      errors++;
      $display("FAIL reset_written got=%h exp=00", written);
    end
    checks++;
    if (any_written !== 1'b0) begin
      errors++;
      $display("FAIL reset_any got=%b exp=0", any_written);
    end
    checks++;
    if (words !== 128'h0) begin
      errors++;
      $display("FAIL reset_words got=%h exp=0", words);
    end
  endtask

  task automatic test_write_readback();
    logic [15:0] exp;
    for (int k = 0; k < 8; k++) begin
      do_write(3'(k), 16'(16'h1111 * k + 1));
    end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      exp_q.push_back(model[a]);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (out !== exp) begin
        errors++;
        $display("FAIL wr_readback addr=%0d got=%h exp=%h", a, out, exp);
      end
    end
    checks++;
    if (written !== 8'hFF) begin
      errors++;
      $display("FAIL wr_written got=%h exp=ff", written);
    end
    checks++;
    if (words[127:112] !== 16'h7778) begin
      errors++;
      $display("FAIL wr_word7 got=%h exp=7778", words[127:112]);
    end
    checks++;
    if (any_written !== 1'b1) begin
      errors++;
      $display("FAIL wr_any got=%b exp=1", any_written);
    end
  endtask

  task automatic test_read_during_write();
    logic [15:0] exp;
    do_write(3'd3, 16'hA5A5);
    address = 3'd3;
    in_d    = 16'h5A5A;
    load    = 1'b1;
    exp_q.push_back(16'hA5A5);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL rdw_old got=%h exp=%h", out, exp);
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    model[3] = 16'h5A5A;
    model_wr[3] = 1'b1;
    exp_q.push_back(16'h5A5A);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL rdw_new got=%h exp=%h", out, exp);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (words[k*16 +: 16] !== model[k]) begin
        errors++;
        $display("FAIL rdw_words k=%0d got=%h exp=%h", k, words[k*16 +: 16], model[k]);
      end
    end
  endtask

  task automatic test_clear_vs_load();
    logic [15:0] exp;
    for (int k = 0; k < 8; k++) begin
      do_write(3'(k), 16'($urandom_range(1, 16'hFFFE)));
    end
    checks++;
    if (written !== 8'hFF) begin
      errors++;
      $display("FAIL clr_pre_written got=%h exp=ff", written);
    end
    clear   = 1'b1;
    load    = 1'b1;
    in_d    = 16'hBEEF;
    address = 3'd2;
    @(posedge clk);
    #1;
    clear = 1'b0;
    load  = 1'b0;
    model_reset();
    checks++;
    if (words !== 128'h0) begin
      errors++;
      $display("FAIL clr_words got=%h exp=0", words);
    end
    checks++;
    if (written !== 8'h00 || any_written !== 1'b0) begin
      errors++;
      $display("FAIL clr_written got=%h/%b exp=00/0", written, any_written);
    end
    address = 3'd2;
    exp_q.push_back(model[2]);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL clr_word2 got=%h exp=%h", out, exp);
    end
  endtask

  task automatic test_reset_burst();
    logic [15:0] exp;
    do_write(3'd1, 16'h0F0F);
    // A low pulse on rst_n between edges must not disturb anything.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    checks++;
    if (words[31:16] !== 16'h0F0F || written !== 8'h02) begin
      errors++;
      $display("FAIL rst_between got=%h/%h exp=0f0f/02", words[31:16], written);
    end
    address = 3'd5;
    load    = 1'b1;
    in_d    = 16'h1234;
    @(posedge clk);
    #1;
    in_d  = 16'h2345;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load  = 1'b0;
    model_reset();
    address = 3'd5;
    exp_q.push_back(model[5]);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL rst_burst_word5 got=%h exp=%h", out, exp);
    end
    checks++;
    if (written !== 8'h00) begin
      errors++;
      $display("FAIL rst_burst_written got=%h exp=00", written);
    end
    do_write(3'd5, 16'h3456);
    checks++;
    if (written !== 8'h20) begin
      errors++;
      $display("FAIL rst_burst_next got=%h exp=20", written);
    end
    checks++;
    if (words[95:80] !== 16'h3456) begin
      errors++;
      $display("FAIL rst_burst_data got=%h exp=3456", words[95:80]);
    end
  endtask

  task automatic test_zero_write();
    logic [15:0] exp;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    do_write(3'd7, 16'h0000);
    address = 3'd7;
    exp_q.push_back(model[7]);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL zero_word7 got=%h exp=%h", out, exp);
    end
    checks++;
    if (written !== 8'h80 || any_written !== 1'b1) begin
      errors++;
      $display("FAIL zero_status got=%h/%b exp=80/1", written, any_written);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    logic [2:0]  a;
    logic [15:0] d;
    // Consecutive-cycle writes, including repeats to the same address.
    for (int n = 0; n < 24; n++) begin
      a = (n % 4 == 3) ? address : 3'($urandom_range(0, 7));
      d = 16'($urandom_range(0, 16'hFFFF));
      address = a;
      in_d    = d;
      load    = 1'b1;
      @(posedge clk);
      #1;
      model[a] = d;
      model_wr[a] = 1'b1;
    end
    load = 1'b0;
    for (int a2 = 0; a2 < 8; a2++) begin
      address = 3'(a2);
      exp_q.push_back(model[a2]);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (out !== exp) begin
        errors++;
        $display("FAIL b2b_out addr=%0d got=%h exp=%h", a2, out, exp);
      end
    end
    checks++;
    if (written !== model_wr || any_written !== (|model_wr)) begin
      errors++;
      $display("FAIL b2b_written got=%h exp=%h", written, model_wr);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    in_d    = 16'h0000;
    address = 3'd0;
    model_reset();
    test_reset();
    test_write_readback();
    test_read_during_write();
    test_clear_vs_load();
    test_reset_burst();
    test_zero_write();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram8_bank.md
# ram8_bank

Eight-word by 16-bit register bank for the HACK memory hierarchy: the storage stage that sits directly upstream of the 8-way 16-bit read multiplexer. It decodes `address` to route a `load` strobe to one of eight 16-bit registers and presents all eight register words to the read mux. It also adds a synchronous bulk-clear and a per-word written-status vector for the RAM64/RAM512 controllers above it.

## Interface

Parameters:
- WIDTH, 16, data word width; the design is only required to work at 16
- DEPTH, 8, number of words; fixed at 8, matching the 3-bit address

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous and active-low
- in  input  16  write data
- address  input  3  word select for both write and read
- load  input  1  write strobe; writes `in` to word `address` at the next edge
- clear  input  1  synchronous bulk clear of all words and status
- out  output  16  read data = word[address], through the 8-way read mux
- words  output  128  all eight register words concatenated, word 0 in bits [15:0]; feeds the read mux directly
- written  output  8  bit k = 1 if word k has been loaded since the last reset/clear
- any_written  output  1  OR-reduction of `written`

## Operation

- Storage: eight 16-bit registers word[0..7] and an 8-bit register `written`.
- Write: at a rising edge with rst_n=1, clear=0 and load=1:
  - word[address] <= in
  - written[address] <= 1
  - All other words and status bits hold.
- Load decode: one-hot 3-to-8 demux of `load` by `address`. Exactly one register enable may be active per cycle.
- Read: out = word[address], combinational, through the 8-way 16-bit mux. There is no read latency and no read enable.
- Clear: at a rising edge with rst_n=1 and clear=1, all words <= 0 and written <= 0. This overrides a simultaneous load, so the load is dropped.
- Priority at the clock edge: rst_n=0, then clear=1, then load=1, then hold.
- Reset (rst_n=0 at the edge): all words = 16'h0000, written = 8'h00, any_written = 0. `out` therefore reads 0 for every address on the first cycle after reset.
- Reset mid-operation: a reset edge coincident with load discards the write. Reset takes effect only on a clock edge; asserting rst_n low between edges changes nothing.
- Width rules: no arithmetic. `in` is stored bit-exact, with no sign or zero extension. `address` values 0..7 are all valid, so there is no out-of-range case.
- Status semantics: a `written` bit is sticky. Rewriting the same word keeps it at 1, and writing 16'h0000 still sets it.

## Timing

- Write latency is 1 cycle: data loaded at edge N is visible on `out` (with address unchanged) and on `words` immediately after edge N.
- Read-during-write: in the cycle where load=1 and address=k, `out` shows the old word[k]. The new value appears after the edge; there is no write-through bypass.
- `written` and `any_written` update on the same edge as the data.
- All outputs are glitch-free with respect to the clock except `out`, which follows `address` combinationally within the cycle.
- Back-to-back writes to any addresses, including the same address, are allowed every cycle with no stall.

## Test plan

- Reset: hold rst_n=0 for 2 edges with load=1, in=16'hFFFF. Then, sweeping address 0..7 -> out=16'h0000 at every address, written=8'h00, any_written=0.
- Write and readback: on successive cycles load word k with 16'h1111*k+1 (k=0..7), then sweep addresses -> out matches each value, written=8'hFF, words[127:112]=16'h7778.
- Read-during-write: word 3 = 16'hA5A5. Write 16'h5A5A to address 3 -> out=16'hA5A5 during the write cycle and 16'h5A5A on the next cycle, with all other words unchanged.
- Clear vs load: words loaded and written=8'hFF, then clear=1 and load=1 with in=16'hBEEF, address=2 in the same cycle -> all words 0, written=8'h00, word 2 != 16'hBEEF.
- Reset during a write burst: writing address 5 every cycle, drop rst_n for one edge -> that write is lost, word 5=0, written[5]=0. The next write after rst_n=1 sets written=8'h20.
- Zero write sets status: after reset, load 16'h0000 to address 7 -> word 7 reads 0, written=8'h80, any_written=1.
